action_select_ctrl: RTL
=======================

Name: action_select_ctrl

Overview:
- Sequences the shared Q-value mux to pick an action for the current state.
- On `start`, steps the mux select through every action and tracks the maximum Q-value and its index (argmax).
- Applies epsilon-greedy exploration using an internal LFSR.
- Returns the chosen action, the max Q (for the Q-update target) and an explore flag. Sits between the Q-table read path and the agent/update FSM.

Parameters:
- DATA_WIDTH, 32, Q-value width; two's-complement signed.
- ACTIONS, 4, number of actions (mux channels); must be >= 2.
- ACTIONS_WIDTH, 2, ceil(log2(ACTIONS)).
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.
- EPS_THRESH, 8'd26, exploration threshold out of 256 (about 10%); 0 means never explore.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a selection; accepted only in IDLE.
- greedy_only  in  1  sampled with start; 1 forces the greedy choice.
- mux_data  in  DATA_WIDTH  Q-value returned by the mux (combinational from mux_sel).
- mux_sel  out  ACTIONS_WIDTH  mux select.
- mux_en  out  1  mux enable; high only in SCAN.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; results valid.
- action  out  ACTIONS_WIDTH  chosen action.
- max_q  out  DATA_WIDTH  maximum Q over all actions.
- explored  out  1  1 if the action came from the random branch.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - mux_sel=0, mux_en=0, busy=0, done=0.
  - action=0, max_q=0, explored=0.
  - lfsr=LFSR_SEED; scan index, best value and best index cleared.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in every state (not gated by start). Never reaches zero.
- FSM IDLE → SCAN → DONE → IDLE.
- IDLE, start=1 at edge T:
  - Latch explore_q = !greedy_only && (lfsr[7:0] < EPS_THRESH), using the pre-shift lfsr.
  - Latch rand_act = lfsr[8+ACTIONS_WIDTH-1:8]; if rand_act >= ACTIONS, subtract ACTIONS.
  - Clear idx to 0; go to SCAN.
- SCAN, ACTIONS cycles (idx = 0..ACTIONS-1):
  - mux_sel=idx, mux_en=1; mux_data is sampled the same cycle.
  - idx==0: best=mux_data, best_idx=0.
  - Otherwise: signed compare; update only if mux_data > best (strict), so ties keep the lowest index.
  - After idx==ACTIONS-1, go to DONE.
- DONE, one cycle:
  - done=1, max_q=best, explored=explore_q.
  - action = explore_q ? rand_act : best_idx.
  - Next state IDLE.
- Outputs:
  - action, max_q and explored are registered and held until the next DONE.
  - done is asserted in the DONE state, then low.
  - mux_en=0 and mux_sel=0 outside SCAN.
- Latency: start at edge T → done high in the cycle after edge T+ACTIONS, i.e. ACTIONS+1 cycles. Back-to-back start is accepted the cycle after DONE.
- start while busy is ignored and not queued.
- greedy_only and mux_data are don't-care outside the cycles where they are sampled.
- Reset mid-scan aborts immediately: no done, and the held outputs clear to 0.
- max_q is the true maximum even when explored=1.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; lfsr=16'hACE1 after release.
- Greedy scan, ACTIONS=4, greedy_only=1, Q={5,-3,12,7} → mux_sel walks 0,1,2,3 with mux_en=1; done exactly 5 cycles after start; action=2, max_q=12, explored=0.
- Signed/tie handling, greedy_only=1, Q={-8,-2,-2,-9} → action=1, max_q=-2. All Q=-1 → action=0.
- Exploration:
  - EPS_THRESH=255, greedy_only=0 → explored=1 on almost all of 1000 runs, and action equals the folded lfsr[9:8] captured at start; max_q is still correct.
  - EPS_THRESH=0 → explored=0 on every run.
  - ACTIONS=3 → action is never 3.
- Protocol: start pulsed again during SCAN → ignored, one done only. start held high continuously → one done every ACTIONS+2 cycles.
- Reset asserted on the 2nd SCAN cycle → no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/action_select_ctrl.sv
// action_select_ctrl: scans Q-values through a shared mux, picks argmax with epsilon-greedy exploration
module action_select_ctrl #(
   parameter int          DATA_WIDTH    = 32,
   parameter int          ACTIONS       = 4,
   parameter int          ACTIONS_WIDTH = 2,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic [7:0]  EPS_THRESH    = 8'd26
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     greedy_only,
   input  logic [DATA_WIDTH-1:0]    mux_data,
   output logic [ACTIONS_WIDTH-1:0] mux_sel,
   output logic                     mux_en,
   output logic                     busy,
   output logic                     done,
   output logic [ACTIONS_WIDTH-1:0] action,
   output logic [DATA_WIDTH-1:0]    max_q,
   output logic                     explored
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t                          r_state, w_next;
   logic [15:0]                     r_lfsr;
   logic [ACTIONS_WIDTH-1:0]        r_idx, r_best_idx, r_rand, w_rand_raw, w_rand, w_best_idx_nxt;
   logic signed [DATA_WIDTH-1:0]    r_best, w_best_nxt;
   logic                            r_explore, w_explore, w_take, w_last, w_fb;

   assign w_fb           = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_last         = r_idx == ACTIONS_WIDTH'(ACTIONS - 1);
   // index 0 seeds the running max; later entries replace it only when strictly larger
   assign w_take         = (r_idx == '0) || ($signed(mux_data) > r_best);
   assign w_best_nxt     = w_take ? $signed(mux_data) : r_best;
   assign w_best_idx_nxt = w_take ? r_idx : r_best_idx;
   assign w_explore      = !greedy_only && (r_lfsr[7:0] < EPS_THRESH);
   assign w_rand_raw     = r_lfsr[8 +: ACTIONS_WIDTH];
   // fold out-of-range random picks back into 0..ACTIONS-1
   assign w_rand         = (32'(w_rand_raw) >= 32'(ACTIONS)) ? w_rand_raw - ACTIONS_WIDTH'(ACTIONS) : w_rand_raw;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next-state and mux/handshake outputs
   always_comb begin
      w_next  = r_state;
      mux_sel = '0;
      mux_en  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (r_state)
         IDLE: w_next = start ? SCAN : IDLE;
         SCAN: begin
            mux_sel = r_idx;
            mux_en  = 1'b1;
            busy    = 1'b1;
            w_next  = w_last ? DONE : SCAN;
         end
         DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // LFSR, scan tracking and result registers; results load on the last scan edge so they are valid with done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr     <= LFSR_SEED;
         r_idx      <= '0;
         r_best     <= '0;
         r_best_idx <= '0;
         r_explore  <= 1'b0;
         r_rand     <= '0;
         action     <= '0;
         max_q      <= '0;
         explored   <= 1'b0;
      end else begin
         r_lfsr <= {w_fb, r_lfsr[15:1]};
         if (r_state == IDLE && start) begin
            r_explore <= w_explore;
            r_rand    <= w_rand;
            r_idx     <= '0;
         end
         if (r_state == SCAN) begin
            r_idx      <= r_idx + 1'b1;
            r_best     <= w_best_nxt;
            r_best_idx <= w_best_idx_nxt;
            if (w_last) begin
               max_q    <= w_best_nxt;
               explored <= r_explore;
               action   <= r_explore ? r_rand : w_best_idx_nxt;
            end
         end
      end
   end
endmodule
